// File: rtl/con_ff_unit.sv
// Registered branch-condition unit: captures the bus operand and IR condition
// field on con_in, evaluates one of eight signed conditions a cycle later.
module con_ff_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              con_in,
  input  logic [2:0]        ir_cond,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              con_clr,
  input  logic              cnt_rst,
  output logic              con_out,
  output logic              busy,
  output logic              eval_done,
  output logic              overrun,
  output logic [CNT_W-1:0]  eval_count,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic {IDLE = 1'b0, EVAL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   op_q, op_d;
  logic [2:0]          cond_q, cond_d;
  logic                con_q, con_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic [CNT_W-1:0]    eval_cnt_q, eval_cnt_d;
  logic [CNT_W-1:0]    taken_cnt_q, taken_cnt_d;

  logic is_zero;
  logic is_neg;
  logic result;

  assign is_zero = (op_q == '0);
  assign is_neg  = op_q[DATA_W-1];

  always_comb begin
    result = 1'b0;
    unique case (cond_q)
      3'b000:  result = is_zero;
      3'b001:  result = !is_zero;
      3'b010:  result = !is_neg && !is_zero;
      3'b011:  result = is_neg;
      3'b100:  result = 1'b1;
      3'b101:  result = 1'b0;
      3'b110:  result = !is_neg;
      3'b111:  result = is_neg || is_zero;
      default: result = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cond_d      = cond_q;
    con_d       = con_q;
    done_d      = 1'b0;
    ovr_d       = ovr_q;
    eval_cnt_d  = eval_cnt_q;
    taken_cnt_d = taken_cnt_q;

    // Clears are applied first so a coincident evaluation or overrun overrides them.
    if (con_clr) begin
      con_d = 1'b0;
      ovr_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (con_in) begin
          op_d    = bus_data;
          cond_d  = ir_cond;
          state_d = EVAL;
        end
      end
      EVAL: begin
        con_d   = result;
        done_d  = 1'b1;
        state_d = IDLE;
        if (con_in) ovr_d = 1'b1;
        if (eval_cnt_q != '1) eval_cnt_d = eval_cnt_q + 1'b1;
        if (result && (taken_cnt_q != '1)) taken_cnt_d = taken_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (cnt_rst) begin
      eval_cnt_d  = '0;
      taken_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cond_q      <= '0;
      con_q       <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      eval_cnt_q  <= '0;
      taken_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cond_q      <= cond_d;
      con_q       <= con_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      eval_cnt_q  <= eval_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign con_out     = con_q;
  assign busy        = (state_q == EVAL);
  assign eval_done   = done_q;
  assign overrun     = ovr_q;
  assign eval_count  = eval_cnt_q;
  assign taken_count = taken_cnt_q;

endmodule

// File: tb/tb_con_ff_unit.sv
// Directed bench for con_ff_unit: a 16-bit-counter instance for function and
// a 2-bit-counter instance sharing its inputs for saturation.
module tb_con_ff_unit;

  localparam int DATA_W = 32;

  logic              clock;
  logic              clear;
  logic              con_in;
  logic [2:0]        ir_cond;
  logic [DATA_W-1:0] bus_data;
  logic              con_clr;
  logic              cnt_rst;

  logic        con_out, busy, eval_done, overrun;
  logic [15:0] eval_count, taken_count;
  logic        s_con_out, s_busy, s_eval_done, s_overrun;
  logic [1:0]  s_eval_count, s_taken_count;

  int n_cmp = 0;
  int n_bad = 0;

  con_ff_unit #(.DATA_W(DATA_W), .CNT_W(16)) u_dut (
    .clock(clock), .clear(clear), .con_in(con_in), .ir_cond(ir_cond),
    .bus_data(bus_data), .con_clr(con_clr), .cnt_rst(cnt_rst),
    .con_out(con_out), .busy(busy), .eval_done(eval_done), .overrun(overrun),
    .eval_count(eval_count), .taken_count(taken_count)
  );

  con_ff_unit #(.DATA_W(DATA_W), .CNT_W(2)) u_sat (
    .clock(clock), .clear(clear), .con_in(con_in), .ir_cond(ir_cond),
    .bus_data(bus_data), .con_clr(con_clr), .cnt_rst(cnt_rst),
    .con_out(s_con_out), .busy(s_busy), .eval_done(s_eval_done), .overrun(s_overrun),
    .eval_count(s_eval_count), .taken_count(s_taken_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_counts(input string tag, input int ev, input int tk, input int sev, input int stk);
    check_eq({tag, ".eval_count"}, 32'(eval_count), 32'(ev));
    check_eq({tag, ".taken_count"}, 32'(taken_count), 32'(tk));
    check_eq({tag, ".sat_eval_count"}, 32'(s_eval_count), 32'(sev));
    check_eq({tag, ".sat_taken_count"}, 32'(s_taken_count), 32'(stk));
  endtask

  // Strobe one evaluation, scramble the bus during EVAL, check the result edge.
  task automatic eval_one(input string tag, input logic [2:0] cond, input logic [31:0] data, input logic exp);
    con_in   = 1'b1;
    ir_cond  = cond;
    bus_data = data;
    tick();
    con_in   = 1'b0;
    bus_data = $urandom;
    ir_cond  = 3'($urandom);
    check_eq({tag, ".busy"}, 32'(busy), 32'd1);
    check_eq({tag, ".done_early"}, 32'(eval_done), 32'd0);
    tick();
    check_eq({tag, ".con_out"}, 32'(con_out), 32'(exp));
    check_eq({tag, ".eval_done"}, 32'(eval_done), 32'd1);
    check_eq({tag, ".busy_after"}, 32'(busy), 32'd0);
    $display("eval %s cond=%0d data=0x%08h con_out=%0d", tag, cond, data, con_out);
  endtask

  logic [31:0] operands [5];
  logic [4:0]  exp_tab  [8];

  initial begin
    operands = '{32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    // bit i = expected result for operands[i]
    exp_tab  = '{5'b00001, 5'b11110, 5'b00110, 5'b11000, 5'b11111, 5'b00000, 5'b00111, 5'b11001};

    clear    = 1'b0;
    con_in   = 1'b1;
    ir_cond  = 3'b100;
    bus_data = $urandom;
    con_clr  = 1'b0;
    cnt_rst  = 1'b0;
    repeat (3) tick();
    check_eq("rst.con_out", 32'(con_out), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.eval_done", 32'(eval_done), 32'd0);
    check_eq("rst.overrun", 32'(overrun), 32'd0);
    check_counts("rst", 0, 0, 0, 0);

    con_in = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    repeat (5) tick();
    check_eq("idle.con_out", 32'(con_out), 32'd0);
    check_eq("idle.busy", 32'(busy), 32'd0);
    check_eq("idle.overrun", 32'(overrun), 32'd0);
    check_counts("idle", 0, 0, 0, 0);

    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 5; k++) begin
        logic [4:0] row;
        row = exp_tab[c];
        eval_one($sformatf("sweep_c%0d_op%0d", c, k), 3'(c), operands[k], row[k]);
      end
    end
    eval_one("brnz_5", 3'b001, 32'd5, 1'b1);
    check_counts("sweep", 41, 21, 3, 3);
    check_eq("sweep.overrun", 32'(overrun), 32'd0);

    cnt_rst = 1'b1;
    tick();
    cnt_rst = 1'b0;
    check_counts("cnt_rst", 0, 0, 0, 0);

    for (int i = 0; i < 5; i++) eval_one($sformatf("bral_%0d", i), 3'b100, 32'h1234_0000, 1'b1);
    check_counts("sat_al", 5, 5, 3, 3);
    eval_one("brnv", 3'b101, 32'h0, 1'b0);
    check_counts("sat_nv", 6, 5, 3, 3);
    tick();
    check_counts("sat_hold", 6, 5, 3, 3);

    // Two consecutive strobes: second lands during EVAL and is dropped.
    cnt_rst = 1'b1;
    tick();
    cnt_rst  = 1'b0;
    con_in   = 1'b1;
    ir_cond  = 3'b000;
    bus_data = 32'h0;
    tick();
    bus_data = 32'h55;
    tick();
    con_in = 1'b0;
    check_eq("ovr.con_out", 32'(con_out), 32'd1);
    check_eq("ovr.overrun", 32'(overrun), 32'd1);
    check_eq("ovr.eval_done", 32'(eval_done), 32'd1);
    check_eq("ovr.busy", 32'(busy), 32'd0);
    tick();
    check_eq("ovr.no_second_busy", 32'(busy), 32'd0);
    check_eq("ovr.done_cleared", 32'(eval_done), 32'd0);
    check_counts("ovr", 1, 1, 1, 1);
    check_eq("ovr.hold", 32'(overrun), 32'd1);
    con_clr = 1'b1;
    tick();
    con_clr = 1'b0;
    check_eq("clr.con_out", 32'(con_out), 32'd0);
    check_eq("clr.overrun", 32'(overrun), 32'd0);

    // Operand captured at the strobe; later bus changes must not matter.
    con_in   = 1'b1;
    ir_cond  = 3'b000;
    bus_data = 32'h0;
    tick();
    con_in   = 1'b0;
    bus_data = 32'h5;
    ir_cond  = 3'b101;
    tick();
    check_eq("capture.con_out", 32'(con_out), 32'd1);
    check_counts("capture", 2, 2, 2, 2);

    con_clr = 1'b1;
    tick();
    con_clr = 1'b0;
    check_eq("pre_coll.con_out", 32'(con_out), 32'd0);

    // Evaluation, overrun and both clears all on the same edge.
    con_in  = 1'b1;
    ir_cond = 3'b100;
    tick();
    con_clr = 1'b1;
    cnt_rst = 1'b1;
    tick();
    con_in  = 1'b0;
    con_clr = 1'b0;
    cnt_rst = 1'b0;
    check_eq("coll.con_out", 32'(con_out), 32'd1);
    check_eq("coll.overrun", 32'(overrun), 32'd1);
    check_eq("coll.eval_done", 32'(eval_done), 32'd1);
    check_counts("coll", 0, 0, 0, 0);
    tick();
    check_eq("coll.busy", 32'(busy), 32'd0);
    check_eq("coll.con_hold", 32'(con_out), 32'd1);

    eval_one("pre_async", 3'b110, 32'h10, 1'b1);
    check_counts("pre_async", 1, 1, 1, 1);
    con_in   = 1'b1;
    ir_cond  = 3'b100;
    bus_data = 32'h1;
    tick();
    con_in = 1'b0;
    check_eq("async.busy_before", 32'(busy), 32'd1);
    #2 clear = 1'b0;
    #1;
    check_eq("async.busy", 32'(busy), 32'd0);
    check_eq("async.con_out", 32'(con_out), 32'd0);
    check_eq("async.overrun", 32'(overrun), 32'd0);
    check_counts("async", 0, 0, 0, 0);
    tick();
    check_eq("async.eval_done", 32'(eval_done), 32'd0);
    @(negedge clock);
    clear = 1'b1;
    tick();
    tick();
    check_eq("async.after_done", 32'(eval_done), 32'd0);
    check_counts("async_after", 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
